// File: rtl/inv_round.sv
// AES inverse cipher round: InvShiftRows, column-serial InvSubBytes (4 S-boxes),
// AddRoundKey and, unless it is the final round, a single-cycle InvMixColumns.
package inv_round_pkg;

  // GF(2^8) multiply, reduction polynomial 0x11b
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Byte i sits at row i%4, column i/4; row r rotates right by r columns
  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        r[8*(row + 4*((col + row) % 4)) +: 8] = s[8*(row + 4*col) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      r[32*c      +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      r[32*c + 8  +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      r[32*c + 16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      r[32*c + 24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return r;
  endfunction

endpackage

// Inverse S-box: inverse affine map, then multiplicative inverse as t^254
module inv_sbox
  import inv_round_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  logic [7:0] t, x3, x7, x15, x31, x63, x127;

  always_comb begin
    t    = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
    x3   = gf_mul(gf_mul(t, t), t);
    x7   = gf_mul(gf_mul(x3, x3), t);
    x15  = gf_mul(gf_mul(x7, x7), t);
    x31  = gf_mul(gf_mul(x15, x15), t);
    x63  = gf_mul(gf_mul(x31, x31), t);
    x127 = gf_mul(gf_mul(x63, x63), t);
    y_o  = gf_mul(x127, x127);
  end
endmodule

module inv_round
  import inv_round_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  input  logic         last,
  output logic [127:0] out_data,
  output logic         ready,
  output logic         busy
);
  localparam int unsigned BW = 128;
  localparam int unsigned CW = 32;

  typedef enum logic [2:0] {IDLE, SHIFT, SUB, ADDK, MIX, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [BW-1:0] data_q, data_d, key_q, key_d, out_q, out_d;
  logic          last_q, last_d, ready_q, ready_d, busy_q, busy_d;
  logic [CW-1:0] col_in, col_out;
  logic [BW-1:0] ark;

  assign col_in = data_q[{cnt_q, 5'd0} +: CW];
  assign ark    = data_q ^ key_q;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    inv_sbox u_sbox (.a_i(col_in[8*g +: 8]), .y_o(col_out[8*g +: 8]));
  end

  // Next-state and datapath; a new start is taken in IDLE and DONE alike
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    key_d   = key_q;
    last_d  = last_q;
    out_d   = out_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE, DONE: begin
        if (start && !busy_q) begin
          data_d  = in_data;
          key_d   = in_key;
          last_d  = last;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        data_d  = inv_shift(data_q);
        cnt_d   = 2'd0;
        state_d = SUB;
      end
      SUB: begin
        data_d[{cnt_q, 5'd0} +: CW] = col_out;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = ADDK;
      end
      ADDK: begin
        data_d = ark;
        if (last_q) begin
          out_d   = ark;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          state_d = MIX;
        end
      end
      MIX: begin
        out_d   = inv_mix(data_q);
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      out_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Operand registers carry no reset; they only reach out_q via a completed round
  always_ff @(posedge clk) begin
    data_q <= data_d;
    key_q  <= key_d;
    last_q <= last_d;
  end

  assign out_data = out_q;
  assign ready    = ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_inv_round.sv
// Self-checking bench for inv_round: fixed vectors, corner sequences and random
// operands against a byte-array model of the inverse AES round.
module tb_inv_round;
  logic         clk = 1'b0;
  logic         rst, start, last, ready, busy;
  logic [127:0] in_data, in_key, out_data;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] isb [256];

  typedef struct {
    logic [127:0] d;
    logic [127:0] k;
    logic         l;
    logic [127:0] exp;
    string        name;
  } vec_t;

  always #5 clk = ~clk;

  inv_round dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_key(in_key),
    .last(last), .out_data(out_data), .ready(ready), .busy(busy)
  );

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] w = {v, v};
    logic [15:0] sh = w << n;
    return sh[15:8];
  endfunction

  // Forward S-box from brute-force field inverse, inverted into a lookup table
  task automatic build_isb();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] xb = 8'(x);
      logic [7:0] inv = 8'h00;
      logic [7:0] f;
      for (int y = 1; y < 256; y++) if (gm(xb, 8'(y)) == 8'h01) inv = 8'(y);
      f = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      isb[f] = xb;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k, input logic l);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] base [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = d[8*i +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r + 4*((c + r) % 4)] = s[r + 4*c];
    for (int i = 0; i < 16; i++) t[i] = isb[t[i]] ^ k[8*i +: 8];
    if (!l) begin
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) begin
          s[4*c + j] = 8'h00;
          for (int i = 0; i < 4; i++) s[4*c + j] ^= gm(t[4*c + i], base[(i - j + 4) % 4]);
        end
      t = s;
    end
    for (int i = 0; i < 16; i++) res[8*i +: 8] = t[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One operation: accept, scramble inputs, wait bounded for ready, check all
  task automatic run_op(input logic [127:0] d, input logic [127:0] k, input logic l,
                        input logic [127:0] exp, input string name);
    int lat = 0;
    bit moved = 0;
    logic [127:0] prev;
    @(negedge clk);
    in_data = d; in_key = k; last = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_data = rnd128(); in_key = rnd128(); last = ~l;
    chk({name, " busy_after_accept"}, 128'(busy), 128'(1));
    chk({name, " ready_after_accept"}, 128'(ready), 128'(0));
    prev = out_data;
    while (ready !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (ready !== 1'b1 && out_data !== prev) moved = 1;
    end
    chk({name, " latency"}, 128'(lat), 128'(l ? 6 : 7));
    chk({name, " out_held_while_busy"}, 128'(moved), 128'(0));
    chk({name, " out_data"}, out_data, exp);
    chk({name, " busy_done"}, 128'(busy), 128'(0));
  endtask

  initial begin
    vec_t vecs [4];
    logic [127:0] ad, ak, bd, bk, aexp, hold;
    logic al, bl;
    int lat;
    bit seen;

    build_isb();
    vecs[0] = '{128'h0, 128'h0, 1'b1, {16{8'h52}}, "zero_last"};
    vecs[1] = '{128'h0, {128{1'b1}}, 1'b0, {16{8'had}}, "zero_keyff_mix"};
    vecs[2] = '{128'h52525252525252525252525252526352, 128'h0, 1'b1,
                128'h48484848484848484848004848484848, "byte_order"};
    vecs[3] = '{128'h6363e363_63326363_65636363_63636319, 128'h0, 1'b0,
                128'h00000000_00000000_00000000_455313db, "invmix_col0"};

    rst = 1'b0; start = 1'b0; last = 1'b0; in_data = '0; in_key = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_data", out_data, 128'h0);
    chk("reset ready", 128'(ready), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 4; i++) run_op(vecs[i].d, vecs[i].k, vecs[i].l, vecs[i].exp, vecs[i].name);

    // Result and ready hold in DONE
    hold = out_data;
    repeat (4) @(posedge clk);
    #1;
    chk("done hold out_data", out_data, hold);
    chk("done hold ready", 128'(ready), 128'(1));

    // start held every cycle with operands churning while busy
    ad = rnd128(); ak = rnd128(); al = 1'($urandom_range(0, 1));
    aexp = model(ad, ak, al);
    @(negedge clk); in_data = ad; in_key = ak; last = al; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (ready !== 1'b1 && lat < 20) begin
      @(negedge clk); in_data = rnd128(); in_key = rnd128(); last = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b first latency", 128'(lat), 128'(al ? 6 : 7));
    chk("b2b first out_data", out_data, aexp);
    bd = rnd128(); bk = rnd128(); bl = 1'($urandom_range(0, 1));
    @(negedge clk); in_data = bd; in_key = bk; last = bl;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b accept ready_low", 128'(ready), 128'(0));
    chk("b2b accept busy", 128'(busy), 128'(1));
    chk("b2b accept out_held", out_data, aexp);
    lat = 0;
    while (ready !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b second latency", 128'(lat), 128'(bl ? 6 : 7));
    chk("b2b second out_data", out_data, model(bd, bk, bl));

    // Reset on E3 of an operation aborts it
    @(negedge clk); in_data = rnd128(); in_key = rnd128(); last = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); rst = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("midreset out_data", out_data, 128'h0);
    chk("midreset ready", 128'(ready), 128'(0));
    chk("midreset busy", 128'(busy), 128'(0));
    @(negedge clk); rst = 1'b1; start = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ready === 1'b1 || busy === 1'b1) seen = 1;
    end
    chk("midreset no_ready_pulse", 128'(seen), 128'(0));
    run_op(vecs[0].d, vecs[0].k, vecs[0].l, vecs[0].exp, "after_reset");

    for (int i = 0; i < 30; i++) begin
      ad = rnd128(); ak = rnd128(); al = 1'($urandom_range(0, 1));
      run_op(ad, ak, al, model(ad, ak, al), $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
